// File: rtl/card_datapath_pkg.sv
// Shared types, constants and helpers for the baccarat card datapath.
//   card_t     : 4-bit rank, 0 = empty, 1 = A, 2..10 pip, 11 = J, 12 = Q, 13 = K
//   score_t    : 4-bit score, 0..9
//   SEG_*      : active-low 7-segment patterns, bit order gfedcba
//   card_value : rank -> baccarat value (0..9)
//   hand_score : three-card hand -> score mod 10
//   seg7       : rank -> segment pattern
package baccarat_pkg;

  typedef logic [3:0] card_t;
  typedef logic [3:0] score_t;

  localparam card_t RANK_NONE = 4'd0;
  localparam card_t RANK_A    = 4'd1;
  localparam card_t RANK_J    = 4'd11;
  localparam card_t RANK_Q    = 4'd12;
  localparam card_t RANK_K    = 4'd13;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_J     = 7'b1100001;
  localparam logic [6:0] SEG_Q     = 7'b0011000; // lower-case q
  localparam logic [6:0] SEG_K     = 7'b0001001; // shown as H

  // 10 and court cards count zero; empty slot also zero.
  function automatic score_t card_value(input card_t c);
    return (c >= 4'd10) ? 4'd0 : c;
  endfunction

  // Sum peaks at 27, so a 5-bit accumulator is enough before the mod.
  function automatic score_t hand_score(input card_t a, input card_t b, input card_t c);
    logic [4:0] s;
    s = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
    return score_t'(s % 5'd10);
  endfunction

  function automatic logic [6:0] seg7(input card_t c);
    case (c)
      4'd1:    return SEG_A;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      4'd10:   return SEG_0;
      4'd11:   return SEG_J;
      4'd12:   return SEG_Q;
      4'd13:   return SEG_K;
      default: return SEG_BLANK; // empty, plus unreachable 14/15
    endcase
  endfunction

endpackage

// File: rtl/card_datapath_if.sv
// Game-control handshake between the controller (master) and the card
// datapath (slave): six one-hot load strobes out, scores and third player
// card rank back.
interface card_datapath_if;
  import baccarat_pkg::*;

  logic   load_pcard1, load_pcard2, load_pcard3;
  logic   load_dcard1, load_dcard2, load_dcard3;
  card_t  pcard3;
  score_t pscore;
  score_t dscore;

  modport master (
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    input  pcard3, pscore, dscore
  );

  modport slave (
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    output pcard3, pscore, dscore
  );
endinterface

// File: rtl/card_datapath_dealcard.sv
// dealcard: 16-bit Fibonacci LFSR dealer and the card it currently offers.
//   slow_clock, resetb : clock, synchronous active-low reset (loads SEED)
//   new_card           : rank 1..13 derived from the top nibble of the LFSR
module dealcard
  import baccarat_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic  slow_clock,
  input  logic  resetb,
  output card_t new_card
);

  logic [15:0] lfsr_q, lfsr_d;

  // Taps 16,14,13,11: maximal length, so a non-zero seed never locks up.
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge slow_clock) begin
    if (!resetb) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  // Nibble 0..15 folded onto 1..13; low ranks slightly favoured.
  assign new_card = card_t'(lfsr_q[15:12] % 4'd13) + 4'd1;

endmodule

// File: rtl/card_datapath.sv
// card_datapath: responder side of the game-control handshake.
//   slow_clock, resetb : clock, synchronous active-low reset
//   bus (slave)        : load strobes in; pcard3, pscore, dscore out
//   HEX0..HEX2         : player cards 1..3, active-low gfedcba
//   HEX3..HEX5         : dealer cards 1..3, active-low gfedcba
//   protocol_err       : sticky flag for multi-strobe or reload attempts
module card_datapath
  import baccarat_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       slow_clock,
  input  logic       resetb,
  card_datapath_if.slave bus,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       protocol_err
);

  card_t             new_card;
  card_t [5:0]       card_q, card_d; // [0..2] player, [3..5] dealer
  logic              err_q, err_d;
  logic  [5:0]       ld;

  dealcard #(.SEED(SEED)) u_deal (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .new_card   (new_card)
  );

  assign ld = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
               bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

  always_comb begin
    card_d = card_q;
    err_d  = err_q;
    // More than one bit set: drop every write this cycle.
    if ((ld & (ld - 6'd1)) != 6'd0) begin
      err_d = 1'b1;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (ld[i]) begin
          if (card_q[i] != RANK_NONE) err_d     = 1'b1;
          else                        card_d[i] = new_card;
        end
      end
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      card_q <= '0;
      err_q  <= 1'b0;
    end else begin
      card_q <= card_d;
      err_q  <= err_d;
    end
  end

  assign bus.pcard3  = card_q[2];
  assign bus.pscore  = hand_score(card_q[0], card_q[1], card_q[2]);
  assign bus.dscore  = hand_score(card_q[3], card_q[4], card_q[5]);
  assign protocol_err = err_q;

  assign HEX0 = seg7(card_q[0]);
  assign HEX1 = seg7(card_q[1]);
  assign HEX2 = seg7(card_q[2]);
  assign HEX3 = seg7(card_q[3]);
  assign HEX4 = seg7(card_q[4]);
  assign HEX5 = seg7(card_q[5]);

endmodule

// File: tb/tb_card_datapath.sv
module tb_card_datapath;

  localparam int SEED = 16'hACE1;

  logic       gclk;
  logic       rst_n;
  logic [6:0] hex [6];
  logic       perr;

  card_datapath_if bus();

  card_datapath #(.SEED(16'hACE1)) dut (
    .slow_clock   (gclk),
    .resetb       (rst_n),
    .bus          (bus),
    .HEX0         (hex[0]),
    .HEX1         (hex[1]),
    .HEX2         (hex[2]),
    .HEX3         (hex[3]),
    .HEX4         (hex[4]),
    .HEX5         (hex[5]),
    .protocol_err (perr)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // expected segment pattern per rank (gfedcba, active low)
  logic [6:0] seg_tbl [16] = '{7'h7F, 7'b0001000, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
                               7'b0011000, 7'b0001001, 7'h7F, 7'h7F};

  int n_cmp, n_bad;
  int m_lfsr, m_err;
  int m_card [6];
  logic [5:0] ld_v;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_deal(input int l);
    return ((l >> 12) & 15) % 13 + 1;
  endfunction

  function automatic int m_val(input int r);
    return (r >= 10) ? 0 : r;
  endfunction

  function automatic int m_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) & 16'hFFFF) | fb;
  endfunction

  task automatic set_ld(input logic [5:0] v);
    ld_v = v;
    bus.load_pcard1 = v[0]; bus.load_pcard2 = v[1]; bus.load_pcard3 = v[2];
    bus.load_dcard1 = v[3]; bus.load_dcard2 = v[4]; bus.load_dcard3 = v[5];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":pscore"}, int'(bus.pscore), (m_val(m_card[0]) + m_val(m_card[1]) + m_val(m_card[2])) % 10);
    chk({tag, ":dscore"}, int'(bus.dscore), (m_val(m_card[3]) + m_val(m_card[4]) + m_val(m_card[5])) % 10);
    chk({tag, ":pcard3"}, int'(bus.pcard3), m_card[2]);
    chk({tag, ":perr"}, int'(perr), m_err);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s:hex%0d", tag, i), int'(hex[i]), int'(seg_tbl[m_card[i]]));
  endtask

  // one edge: reference model steps on the same edge, then compare
  task automatic tick(input string tag);
    int cnt;
    @(posedge gclk);
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) m_card[i] = 0;
      m_err  = 0;
      m_lfsr = SEED;
    end else begin
      cnt = 0;
      for (int i = 0; i < 6; i++) if (ld_v[i]) cnt++;
      if (cnt > 1) m_err = 1;
      else for (int i = 0; i < 6; i++)
        if (ld_v[i]) begin
          if (m_card[i] != 0) m_err = 1;
          else m_card[i] = m_deal(m_lfsr);
        end
      m_lfsr = m_next(m_lfsr);
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; set_ld(6'b0);
    tick("rst");
    rst_n = 1'b1;
  endtask

  // idle until the model offers rank r, then strobe slot idx
  task automatic deal_rank(input int idx, input int r);
    int n;
    n = 0;
    set_ld(6'b0);
    while (m_deal(m_lfsr) != r && n < 400) begin
      tick("wait");
      n++;
    end
    if (n >= 400) chk("deal_timeout", n, 0);
    set_ld(6'b1 << idx);
    tick("deal");
    set_ld(6'b0);
  endtask

  initial begin
    int r;
    logic [6:0] h_keep;
    n_cmp = 0; n_bad = 0;
    m_lfsr = SEED; m_err = 0;
    for (int i = 0; i < 6; i++) m_card[i] = 0;
    rst_n = 1'b0; set_ld(6'b0);

    // reset with junk strobes
    repeat (2) begin
      set_ld(6'($urandom));
      tick("reset");
    end
    chk("reset_hex0", int'(hex[0]), 7'h7F);
    chk("reset_perr", int'(perr), 0);

    // known sequence from the seed
    rst_n = 1'b1;
    set_ld(6'b000001); tick("first");
    chk("first_j", int'(hex[0]), 7'b1100001);
    set_ld(6'b001000); tick("second");
    chk("second_dscore", int'(bus.dscore), 6);
    set_ld(6'b0);

    // scoring: player 9,K,7 ; dealer A,Q
    do_reset();
    deal_rank(0, 9); deal_rank(1, 13); deal_rank(2, 7);
    chk("p_976_score", int'(bus.pscore), 6);
    chk("p_976_pcard3", int'(bus.pcard3), 7);
    deal_rank(3, 1); deal_rank(4, 12);
    chk("d_aq_score", int'(bus.dscore), 1);
    chk("score_perr", int'(perr), 0);
    do_reset();
    deal_rank(0, 9); deal_rank(1, 9); deal_rank(2, 9);
    chk("p_999_score", int'(bus.pscore), 7);

    // simultaneous strobes
    do_reset();
    set_ld(6'b001001); tick("simul");
    chk("simul_hex0", int'(hex[0]), 7'h7F);
    chk("simul_hex3", int'(hex[3]), 7'h7F);
    chk("simul_perr", int'(perr), 1);
    set_ld(6'b0);
    repeat (5) tick("sticky");
    chk("sticky_perr", int'(perr), 1);
    do_reset();
    chk("cleared_perr", int'(perr), 0);

    // reload of player card 2
    set_ld(6'b000010); tick("load2");
    h_keep = hex[1];
    set_ld(6'b0); tick("gap");
    set_ld(6'b000010); tick("reload2");
    chk("reload_hex1", int'(hex[1]), int'(h_keep));
    chk("reload_perr", int'(perr), 1);
    set_ld(6'b0);

    // reset mid-game after four cards
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_ld(6'b1 << i); tick("mid");
    end
    set_ld(6'b0);
    do_reset();
    chk("mid_hex0", int'(hex[0]), 7'h7F);
    set_ld(6'b000001); tick("mid_first");
    chk("mid_j", int'(hex[0]), 7'b1100001);
    set_ld(6'b0);

    // 200 deals checked against the model, then a random soak
    for (int k = 0; k < 200; k++) begin
      if (m_card[0] != 0 && m_card[5] != 0) do_reset();
      r = $urandom_range(0, 5);
      set_ld(6'b1 << r);
      tick("draw");
    end
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 11);
      if (r < 6)       set_ld(6'b1 << r);
      else if (r == 6) set_ld(6'($urandom) | 6'b000011);
      else             set_ld(6'b0);
      rst_n = (r == 7) ? 1'b0 : 1'b1;
      tick("soak");
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/card_datapath.md
Name: card_datapath

Overview:
- Responder side of the game-control handshake: consumes the six one-hot load strobes issued by the game controller.
- Deals pseudo-random cards into six card registers (3 player, 3 dealer).
- Returns pscore, dscore and pcard3 to the controller.
- Drives six active-low 7-segment digits for the cards, and flags strobe-protocol violations.

Parameters:
- SEED, 16'hACE1, reset value of the dealer LFSR; must be non-zero.

Ports:
- slow_clock  in  1  game clock; all state updates on posedge.
- resetb  in  1  synchronous, active-low reset.
- load_pcard1, load_pcard2, load_pcard3  in  1 each  capture the current dealt card into player card 1/2/3.
- load_dcard1, load_dcard2, load_dcard3  in  1 each  capture the current dealt card into dealer card 1/2/3.
- pcard3  out  4  player third-card rank, 0 = no card.
- pscore  out  4  player score 0..9.
- dscore  out  4  dealer score 0..9.
- HEX0..HEX5  out  7 each  active-low segments gfedcba.
  - HEX0/1/2 show player cards 1/2/3.
  - HEX3/4/5 show dealer cards 1/2/3.
- protocol_err  out  1  sticky violation flag.

Behaviour:
- Reset is sampled on the posedge of slow_clock: resetb=0 at an edge clears all six card registers to 0, loads lfsr<=SEED, and clears protocol_err.
- Reset outputs: pcard3=0, pscore=0, dscore=0, HEX0..5=BLANK (7'b1111111), protocol_err=0.
- Reset mid-game behaves identically; no strobe is honoured on an edge where resetb=0.
- Card encoding: 4-bit rank, 0 = empty, 1 = A, 2..10 = pip, 11 = J, 12 = Q, 13 = K. Values 14/15 never stored.
- Dealer LFSR:
  - 16-bit Fibonacci; advances every edge when resetb=1.
  - lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Dealt card (combinational from the current lfsr): new_card = (lfsr[15:12] mod 13) + 1. Range 1..13; ranks 1..3 are slightly over-weighted, which is accepted.
- Load rule: strobe X high at edge k with resetb=1 and no violation means register X <= new_card as of cycle k. Outputs reflect the card from edge k onward (1-edge latency, same as the lfsr step).
- Violations: set protocol_err=1 (sticky until reset) and block the write in each case below.
  - More than one strobe high in the same cycle: no register is written.
  - A strobe targets a register that is already non-zero: that register keeps its old value.
- LFSR stepping is independent of strobes and violations.
- Card value: A=1, 2..9 = face, 10/J/Q/K = 0. Empty = 0.
- Scores are combinational from the registers, width-safe:
  - pscore = (v(p1)+v(p2)+v(p3)) mod 10; the 5-bit sum ranges 0..27.
  - dscore is computed the same way from the dealer cards.
  - Scores are valid in the same cycle the register updates, so the controller samples them on the next edge.
- pcard3 = player card 3 register, rank not value (the controller needs rank for third-card rules).
- 7-segment per digit, combinational from the card register:
  - 0 -> BLANK, 1 -> A, 2..9 -> digit, 10 -> 0, 11 -> J, 12 -> q, 13 -> H.
  - 14/15 are unreachable; decode them to BLANK.

Decomposition:
- baccarat_pkg contains:
  - typedef card_t (logic [3:0]).
  - rank constants RANK_NONE, RANK_A, RANK_J, RANK_Q, RANK_K.
  - typedef score_t (logic [3:0]).
  - 7-segment constants SEG_BLANK, SEG_0..SEG_9, SEG_A, SEG_J, SEG_Q, SEG_K.
  - function card_value (card_t -> 0..9).
- One sub-module, dealcard: holds the LFSR and new_card generation with parameter SEED. card_datapath instantiates it once.
- The 7-segment decode is a package function, not a module.

Test Plan:
- Reset: hold resetb=0 for 2 edges with random strobes -> all HEX=7'b1111111, pscore=dscore=pcard3=0, protocol_err=0.
- LFSR sequence: SEED=16'hACE1, release reset, pulse load_pcard1 at first edge -> pcard1=11 (J, HEX0=SEG_J). Pulse load_dcard1 at second edge (lfsr=16'h59C3) -> dcard1=6, dscore=6. Check 200 further draws against a bench LFSR model.
- Scoring: force a sequence yielding player 9, K, 7 -> pscore=6, pcard3=7; dealer A, Q -> dscore=1; boundary 9+9+9 -> pscore=7.
- Simultaneous strobes: load_pcard1 and load_dcard1 high at the same edge -> both registers stay 0, protocol_err=1 and stays 1 until resetb=0.
- Reload: load_pcard2 twice on non-consecutive edges -> the second write is ignored, pcard2 is unchanged, protocol_err=1.
- Reset mid-game: after 4 cards are loaded, resetb=0 for one edge -> all cleared, lfsr=SEED, and the next dealt card is again 11.
